// File: rtl/host_bridge_pkg.sv
// Shared types and address-split helpers for the CPU word port to DMA cache-line bridge.
package host_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_GO,
    WB_DATA,
    WB_WAIT,
    FILL_GO,
    FILL_DATA,
    RESP,
    FLUSH_ACK
  } state_t;

  localparam int LINE_W_DFLT = 512;
  localparam int WORD_W_DFLT = 32;

  typedef logic [LINE_W_DFLT-1:0] line_t;
  typedef logic [WORD_W_DFLT-1:0] word_t;

  // Byte-offset bits covering one cache line.
  function automatic int off_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Byte-offset bits covering one CPU word.
  function automatic int wb_bits(input int word_w);
    return $clog2(word_w / 8);
  endfunction

endpackage

// File: rtl/host_line_bridge_line_merge.sv
// Combinational word extract from, and word insert into, a cache line by word index.
module line_merge
  import host_bridge_pkg::*;
#(
  parameter int LINE_W = 512,
  parameter int WORD_W = 32,
  localparam int NW    = LINE_W / WORD_W,
  localparam int IDX_W = $clog2(NW)
) (
  input  logic [LINE_W-1:0] line_in,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] word_out,
  output logic [LINE_W-1:0] line_out
);

  assign word_out = line_in[idx*WORD_W +: WORD_W];

  always_comb begin
    line_out = line_in;
    line_out[idx*WORD_W +: WORD_W] = wdata;
  end

endmodule

// File: rtl/host_line_bridge.sv
// Single-line write-back buffer between a CPU word port and a line DMA; hits answer 1 cycle after accept.
// Misses stall cpu_ready through writeback+fill; DMA strobes wait on dma_full/dma_empty.
module host_line_bridge
  import host_bridge_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int LINE_W     = 512,
  parameter int CPU_ADDR_W = 32,
  parameter int ADDR_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  cpu_req,
  input  logic                  cpu_op,
  input  logic [CPU_ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0]     cpu_wdata,
  output logic                  cpu_ready,
  output logic [WORD_W-1:0]     cpu_rdata,
  output logic                  cpu_rd_valid,
  output logic                  cpu_tx_done,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [ADDR_W-1:0]     dma_rd_addr,
  output logic [ADDR_W-1:0]     dma_wr_addr,
  output logic [CPU_ADDR_W:0]   dma_rd_size,
  output logic [CPU_ADDR_W:0]   dma_wr_size,
  output logic                  dma_rd_go,
  output logic                  dma_wr_go,
  input  logic                  dma_empty,
  input  logic                  dma_full,
  output logic                  dma_rd_en,
  output logic                  dma_wr_en,
  input  logic [LINE_W-1:0]     dma_rd_data,
  output logic [LINE_W-1:0]     dma_wr_data,
  input  logic                  dma_rd_done,
  input  logic                  dma_wr_done
);

  localparam int OFF   = off_bits(LINE_W);
  localparam int WB    = wb_bits(WORD_W);
  localparam int IDX_W = OFF - WB;
  localparam int TAG_W = CPU_ADDR_W - OFF;

  state_t              state;
  logic                run;
  logic                valid;
  logic                dirty;
  logic                flush_mode;
  logic                wait_first;
  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic                req_op;
  logic [WORD_W-1:0]   req_wdata;
  logic [LINE_W-1:0]   line_q;

  logic [TAG_W-1:0]    tag_in;
  logic [IDX_W-1:0]    idx_in;
  logic                hit;
  logic                accept;
  logic                in_resp;
  logic [IDX_W-1:0]    mrg_idx;
  logic [WORD_W-1:0]   mrg_wdata;
  logic [WORD_W-1:0]   mrg_word;
  logic [LINE_W-1:0]   mrg_line;
  logic                unused_ok;

  assign tag_in    = cpu_addr[CPU_ADDR_W-1:OFF];
  assign idx_in    = cpu_addr[OFF-1:WB];
  assign hit       = valid && (tag_in == tag_q);
  // run keeps cpu_ready low while reset is asserted and for the first edge after it
  assign cpu_ready = run && (state == IDLE) && !flush;
  assign accept    = cpu_req && cpu_ready;

  // The merge unit is shared: live request in IDLE, latched request in RESP.
  assign in_resp   = (state == RESP);
  assign mrg_idx   = in_resp ? req_idx : idx_in;
  assign mrg_wdata = in_resp ? req_wdata : cpu_wdata;

  line_merge #(
    .LINE_W (LINE_W),
    .WORD_W (WORD_W)
  ) u_merge (
    .line_in  (line_q),
    .idx      (mrg_idx),
    .wdata    (mrg_wdata),
    .word_out (mrg_word),
    .line_out (mrg_line)
  );

  assign dma_rd_en   = (state == FILL_DATA) && !dma_empty;
  assign dma_wr_en   = (state == WB_DATA) && !dma_full;
  assign dma_wr_data = line_q;
  assign dma_rd_size = (CPU_ADDR_W+1)'(1);
  assign dma_wr_size = (CPU_ADDR_W+1)'(1);

  // Fills complete on the pop itself, so the DMA read-done level carries no extra information.
  assign unused_ok = &{1'b0, dma_rd_done, cpu_addr[WB-1:0]};

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t);
    return base_addr + (ADDR_W'(t) << OFF);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      run          <= 1'b0;
      valid        <= 1'b0;
      dirty        <= 1'b0;
      flush_mode   <= 1'b0;
      wait_first   <= 1'b0;
      tag_q        <= '0;
      req_tag      <= '0;
      req_idx      <= '0;
      req_op       <= 1'b0;
      req_wdata    <= '0;
      line_q       <= '0;
      cpu_rdata    <= '0;
      cpu_rd_valid <= 1'b0;
      cpu_tx_done  <= 1'b0;
      flush_done   <= 1'b0;
      dma_rd_go    <= 1'b0;
      dma_wr_go    <= 1'b0;
      dma_rd_addr  <= '0;
      dma_wr_addr  <= '0;
    end else begin
      run          <= 1'b1;
      cpu_rd_valid <= 1'b0;
      cpu_tx_done  <= 1'b0;
      flush_done   <= 1'b0;
      dma_rd_go    <= 1'b0;
      dma_wr_go    <= 1'b0;

      case (state)
        IDLE: begin
          if (run && flush) begin
            if (dirty) begin
              flush_mode  <= 1'b1;
              dma_wr_go   <= 1'b1;
              dma_wr_addr <= line_addr(tag_q);
              state       <= WB_GO;
            end else begin
              flush_done <= 1'b1;
            end
          end else if (accept) begin
            if (hit) begin
              if (cpu_op) begin
                line_q <= mrg_line;
                dirty  <= 1'b1;
              end else begin
                cpu_rdata    <= mrg_word;
                cpu_rd_valid <= 1'b1;
              end
              cpu_tx_done <= 1'b1;
            end else begin
              req_tag    <= tag_in;
              req_idx    <= idx_in;
              req_op     <= cpu_op;
              req_wdata  <= cpu_wdata;
              flush_mode <= 1'b0;
              if (dirty) begin
                dma_wr_go   <= 1'b1;
                dma_wr_addr <= line_addr(tag_q);
                state       <= WB_GO;
              end else begin
                dma_rd_go   <= 1'b1;
                dma_rd_addr <= line_addr(tag_in);
                state       <= FILL_GO;
              end
            end
          end
        end

        WB_GO: state <= WB_DATA;

        WB_DATA: begin
          if (!dma_full) begin
            wait_first <= 1'b1;
            state      <= WB_WAIT;
          end
        end

        // wr_done may still be high from the previous transfer on the first cycle here
        WB_WAIT: begin
          wait_first <= 1'b0;
          if (!wait_first && dma_wr_done) begin
            dirty <= 1'b0;
            if (flush_mode) begin
              flush_done <= 1'b1;
              state      <= FLUSH_ACK;
            end else begin
              dma_rd_go   <= 1'b1;
              dma_rd_addr <= line_addr(req_tag);
              state       <= FILL_GO;
            end
          end
        end

        FILL_GO: state <= FILL_DATA;

        FILL_DATA: begin
          if (!dma_empty) begin
            line_q <= dma_rd_data;
            valid  <= 1'b1;
            tag_q  <= req_tag;
            state  <= RESP;
          end
        end

        RESP: begin
          if (req_op) begin
            line_q <= mrg_line;
            dirty  <= 1'b1;
          end else begin
            cpu_rdata    <= mrg_word;
            cpu_rd_valid <= 1'b1;
          end
          cpu_tx_done <= 1'b1;
          state       <= IDLE;
        end

        FLUSH_ACK: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_line_bridge.sv
// Directed bench: flat word-memory reference model, DMA line-memory responder and per-cycle compare.
module tb_host_line_bridge;
  import host_bridge_pkg::*;

  localparam logic [63:0] BASE = 64'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] base_addr = BASE;
  logic        cpu_req = 1'b0;
  logic        cpu_op = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_rd_valid;
  logic        cpu_tx_done;
  logic        flush = 1'b0;
  logic        flush_done;
  logic [63:0] dma_rd_addr, dma_wr_addr;
  logic [32:0] dma_rd_size, dma_wr_size;
  logic        dma_rd_go, dma_wr_go;
  logic        dma_empty = 1'b1;
  logic        dma_full = 1'b0;
  logic        dma_rd_en, dma_wr_en;
  line_t       dma_rd_data = '0;
  line_t       dma_wr_data;
  logic        dma_rd_done = 1'b0;
  logic        dma_wr_done = 1'b0;

  always #5 clk = ~clk;

  host_line_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .base_addr    (base_addr),
    .cpu_req      (cpu_req),
    .cpu_op       (cpu_op),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ready    (cpu_ready),
    .cpu_rdata    (cpu_rdata),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_tx_done  (cpu_tx_done),
    .flush        (flush),
    .flush_done   (flush_done),
    .dma_rd_addr  (dma_rd_addr),
    .dma_wr_addr  (dma_wr_addr),
    .dma_rd_size  (dma_rd_size),
    .dma_wr_size  (dma_wr_size),
    .dma_rd_go    (dma_rd_go),
    .dma_wr_go    (dma_wr_go),
    .dma_empty    (dma_empty),
    .dma_full     (dma_full),
    .dma_rd_en    (dma_rd_en),
    .dma_wr_en    (dma_wr_en),
    .dma_rd_data  (dma_rd_data),
    .dma_wr_data  (dma_wr_data),
    .dma_rd_done  (dma_rd_done),
    .dma_wr_done  (dma_wr_done)
  );

  longint checks = 0, failures = 0;
  longint ncyc = 0, wr_gos = 0, rd_gos = 0, wr_pushes = 0, rd_pops = 0;
  longint last_pop_cyc = 0, last_wr_go_cyc = 0, last_rd_go_cyc = 0, last_done_cyc = 0;
  longint done_cnt = 0, accepted = 0;
  logic [63:0] wr_addr_cap = '0, rd_addr_cap = '0;
  line_t  last_push_data = '0;
  word_t  last_rdata = '0;
  logic   hold_empty = 1'b0, hold_full = 1'b0, dma_rst = 1'b0;
  int     rd_lat = 0, wr_lat = 0;
  bit     rd_pending = 1'b0;

  word_t  ref_mem [logic [31:0]];
  line_t  dmem [logic [63:0]];
  word_t  exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic word_t init_word(input logic [31:0] wa);
    return {wa[15:0], ~wa[15:0]};
  endfunction

  function automatic line_t init_line(input logic [63:0] a);
    line_t l;
    logic [31:0] first;
    first = 32'((a - BASE) >> 6) << 4;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = init_word(first + 32'(i));
    return l;
  endfunction

  function automatic word_t ref_read(input logic [31:0] addr);
    logic [31:0] wa;
    wa = addr >> 2;
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  // DMA side: inputs change at the falling edge, strobes sampled just after it.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (dma_rst) begin
        rd_pending  = 1'b0;
        wr_lat      = 0;
        rd_lat      = 0;
        dma_wr_done = 1'b0;
        dma_rd_done = 1'b0;
      end else begin
        if (wr_lat > 0) begin
          wr_lat--;
          if (wr_lat == 0) dma_wr_done = 1'b1;
        end
        if (rd_lat > 0) rd_lat--;
      end
      dma_empty = hold_empty || !(rd_pending && rd_lat == 0);
      dma_full  = hold_full;
      #1;
      if (dma_wr_go) begin
        wr_gos++;
        wr_addr_cap    = dma_wr_addr;
        last_wr_go_cyc = ncyc;
        dma_wr_done    = 1'b0;
      end
      if (dma_wr_en && !dma_full) begin
        wr_pushes++;
        dmem[wr_addr_cap] = dma_wr_data;
        last_push_data    = dma_wr_data;
        wr_lat            = 3;
      end
      if (dma_rd_go) begin
        rd_gos++;
        rd_addr_cap    = dma_rd_addr;
        last_rd_go_cyc = ncyc;
        dma_rd_done    = 1'b0;
        dma_rd_data    = dmem.exists(dma_rd_addr) ? dmem[dma_rd_addr] : init_line(dma_rd_addr);
        rd_pending     = 1'b1;
        rd_lat         = 2;
      end
      if (dma_rd_en && !dma_empty) begin
        rd_pops++;
        last_pop_cyc = ncyc;
        rd_pending   = 1'b0;
        dma_rd_done  = 1'b1;
      end
    end
  end

  // Per-cycle compare against the reference model and the DMA strobe rules.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("rd_en_while_empty", 64'(dma_rd_en & dma_empty), 0);
      chk("wr_en_while_full", 64'(dma_wr_en & dma_full), 0);
      if (flush) chk("ready_under_flush", 64'(cpu_ready), 0);
      if (cpu_rd_valid) begin
        last_rdata = cpu_rdata;
        chk("rd_valid_with_done", 64'(cpu_tx_done), 1);
        if (exp_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
        else chk("rdata", 64'(cpu_rdata), 64'(exp_q.pop_front()));
      end
      if (cpu_tx_done) done_cnt++;
    end
  end

  task automatic do_req(input logic op, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat);
    int waited;
    lat = -1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_op = op; cpu_addr = addr; cpu_wdata = wd;
    waited = 0;
    forever begin
      @(negedge clk); #3;
      if (cpu_ready) break;
      waited++;
      if (waited > 300) begin
        chk("accept_timeout", 1, 0);
        cpu_req = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    accepted++;
    if (op) ref_mem[addr >> 2] = wd;
    else exp_q.push_back(ref_read(addr));
    lat = 0;
    forever begin
      @(negedge clk); #3;
      lat++;
      if (cpu_tx_done) begin
        last_done_cyc = ncyc;
        break;
      end
      if (lat > 300) begin
        chk("done_timeout", 1, 0);
        return;
      end
    end
  endtask

  initial begin
    int lat;
    int waited;
    int ready_hi;
    int en_hi;
    longint b_wr, b_rd, b_push, b_pop;

    // Reset state
    repeat (2) @(negedge clk);
    #3;
    chk("rst_cpu_ready", 64'(cpu_ready), 0);
    chk("rst_rd_valid", 64'(cpu_rd_valid), 0);
    chk("rst_tx_done", 64'(cpu_tx_done), 0);
    chk("rst_rdata", 64'(cpu_rdata), 0);
    chk("rst_flush_done", 64'(flush_done), 0);
    chk("rst_gos", 64'({dma_rd_go, dma_wr_go}), 0);
    chk("rst_ens", 64'({dma_rd_en, dma_wr_en}), 0);
    chk("rst_rd_addr", dma_rd_addr, 0);
    chk("rst_wr_addr", dma_wr_addr, 0);
    chk("rst_wr_data", 64'(|dma_wr_data), 0);
    chk("rst_rd_size", 64'(dma_rd_size), 1);
    chk("rst_wr_size", 64'(dma_wr_size), 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("post_rst_ready", 64'(cpu_ready), 1);

    // Write miss on an empty buffer: fill only, then merge
    b_wr = wr_gos; b_rd = rd_gos;
    do_req(1'b1, 32'h44, 32'hDEADBEEF, lat);
    chk("w44_no_wr_go", 64'(wr_gos - b_wr), 0);
    chk("w44_rd_go", 64'(rd_gos - b_rd), 1);
    chk("w44_rd_addr", rd_addr_cap, 64'h1000_0040);
    chk("w44_done_after_pop", 64'(last_done_cyc - last_pop_cyc), 2);

    // Read hit
    b_wr = wr_gos; b_rd = rd_gos;
    do_req(1'b0, 32'h44, 32'h0, lat);
    chk("r44_hit_latency", 64'(lat), 1);
    chk("r44_rdata_literal", 64'(last_rdata), 64'hDEADBEEF);
    chk("r44_no_dma", 64'((wr_gos - b_wr) + (rd_gos - b_rd)), 0);

    // Read miss on a dirty line: writeback then fill
    b_wr = wr_gos; b_rd = rd_gos;
    do_req(1'b0, 32'h80, 32'h0, lat);
    chk("r80_wr_go", 64'(wr_gos - b_wr), 1);
    chk("r80_wr_addr", wr_addr_cap, 64'h1000_0040);
    chk("r80_wb_word1", 64'(last_push_data[63:32]), 64'hDEADBEEF);
    chk("r80_rd_go", 64'(rd_gos - b_rd), 1);
    chk("r80_rd_addr", rd_addr_cap, 64'h1000_0080);
    chk("r80_wb_before_fill", 64'(last_wr_go_cyc < last_rd_go_cyc), 1);
    chk("r80_rdata_literal", 64'(last_rdata), 64'h0020FFDF);

    // DMA stalled 20 cycles in the middle of a dirty miss
    do_req(1'b1, 32'h84, 32'h1234_5678, lat);
    chk("w84_hit_latency", 64'(lat), 1);
    b_push = wr_pushes; b_pop = rd_pops; b_wr = wr_gos;
    hold_empty = 1'b1; hold_full = 1'b1;
    ready_hi = 0; en_hi = 0;
    fork
      do_req(1'b0, 32'hC4, 32'h0, lat);
      begin
        waited = 0;
        while (wr_gos == b_wr && waited < 300) begin
          @(negedge clk); #3; waited++;
        end
        repeat (20) begin
          @(negedge clk); #3;
          ready_hi += int'(cpu_ready);
          en_hi    += int'(dma_rd_en | dma_wr_en);
        end
        hold_empty = 1'b0; hold_full = 1'b0;
      end
    join
    chk("stall_ready_low", 64'(ready_hi), 0);
    chk("stall_no_strobes", 64'(en_hi), 0);
    chk("stall_one_push", 64'(wr_pushes - b_push), 1);
    chk("stall_one_pop", 64'(rd_pops - b_pop), 1);
    chk("stall_wb_addr", wr_addr_cap, 64'h1000_0080);

    // Flush on a clean buffer
    b_wr = wr_gos;
    @(posedge clk); #1;
    flush = 1'b1; cpu_req = 1'b1; cpu_op = 1'b0; cpu_addr = 32'hC4;
    @(negedge clk); #3;
    chk("flush_clean_not_yet", 64'(flush_done), 0);
    @(negedge clk); #3;
    chk("flush_clean_done", 64'(flush_done), 1);
    @(posedge clk); #1;
    flush = 1'b0; cpu_req = 1'b0;
    chk("flush_clean_no_wr_go", 64'(wr_gos - b_wr), 0);

    // Flush on a dirty buffer
    do_req(1'b1, 32'hC8, 32'h5555_AAAA, lat);
    b_push = wr_pushes; b_rd = rd_gos;
    @(posedge clk); #1;
    flush = 1'b1;
    waited = 0;
    do begin
      @(negedge clk); #3; waited++;
    end while (!flush_done && waited < 300);
    chk("flush_dirty_done", 64'(flush_done), 1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_dirty_one_push", 64'(wr_pushes - b_push), 1);
    chk("flush_dirty_addr", wr_addr_cap, 64'h1000_00C0);
    chk("flush_dirty_word2", 64'(last_push_data[95:64]), 64'h5555AAAA);
    for (int i = 0; i < 16; i++)
      chk("flush_line_vs_model", 64'(dmem[64'h1000_00C0][i*32 +: 32]),
          64'(ref_read(32'hC0 + 32'(i*4))));
    do_req(1'b0, 32'hC8, 32'h0, lat);
    chk("after_flush_hit", 64'(lat), 1);
    chk("after_flush_no_rd_go", 64'(rd_gos - b_rd), 0);

    // Reset while waiting for fill data
    hold_empty = 1'b1;
    b_rd = rd_gos;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_op = 1'b0; cpu_addr = 32'h44;
    waited = 0;
    do begin
      @(negedge clk); #3; waited++;
    end while (!cpu_ready && waited < 300);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    waited = 0;
    while (rd_gos == b_rd && waited < 300) begin
      @(negedge clk); #3; waited++;
    end
    repeat (3) @(negedge clk);
    #3;
    chk("pre_rst_rd_addr", dma_rd_addr, 64'h1000_0040);
    rst_n = 1'b0; dma_rst = 1'b1;
    #1;
    chk("arst_cpu_ready", 64'(cpu_ready), 0);
    chk("arst_rd_addr", dma_rd_addr, 0);
    chk("arst_rdata", 64'(cpu_rdata), 0);
    chk("arst_wr_data", 64'(|dma_wr_data), 0);
    chk("arst_ens", 64'({dma_rd_en, dma_wr_en}), 0);
    repeat (2) @(negedge clk);
    #3;
    hold_empty = 1'b0; rst_n = 1'b1; dma_rst = 1'b0;
    b_rd = rd_gos;
    do_req(1'b0, 32'h44, 32'h0, lat);
    chk("post_arst_refill", 64'(rd_gos - b_rd), 1);
    chk("post_arst_rd_addr", rd_addr_cap, 64'h1000_0040);
    chk("post_arst_rdata", 64'(last_rdata), 64'hDEADBEEF);

    repeat (3) @(negedge clk);
    chk("all_requests_done", 64'(done_cnt), 64'(accepted));
    chk("no_pending_reads", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
